// File: rtl/pt_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pt_vga_pkg
// Brief    : Shared widths, screen limits, requester indices and colours for
//            the VGA plot path.
// Revision : 1.0  initial release
// ============================================================================
package pt_vga_pkg;

    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int COLOUR_W  = 3;

    localparam int DEF_X_RES = 320;
    localparam int DEF_Y_RES = 240;

    localparam int REQ_RESET     = 0;
    localparam int REQ_DRAW      = 1;
    localparam int REQ_LINE      = 2;
    localparam int REQ_CORRECT   = 3;
    localparam int REQ_INCORRECT = 4;

    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_plot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter_if
// Brief    : Requester-side request/pixel bundle and adapter-side plot outputs.
// Revision : 1.0  initial release
// ============================================================================
interface vga_plot_arbiter_if
    import pt_vga_pkg::*;
#(
    parameter int NUM_REQ = 5
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          pix_valid;
    logic [NUM_REQ-1:0]          last;
    logic [NUM_REQ*X_W-1:0]      x_in;
    logic [NUM_REQ*Y_W-1:0]      y_in;
    logic [NUM_REQ*COLOUR_W-1:0] colour_in;
    logic                        err_clear;

    logic [NUM_REQ-1:0]          grant;
    logic                        plot;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        busy;
    logic                        timeout_err;

    modport master (
        output req, pix_valid, last, x_in, y_in, colour_in, err_clear,
        input  grant, plot, x, y, colour, busy, timeout_err
    );

    modport slave (
        input  req, pix_valid, last, x_in, y_in, colour_in, err_clear,
        output grant, plot, x, y, colour, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/fixed_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : fixed_prio_enc
// Brief    : Isolates the lowest set request bit (index 0 = highest priority).
// Revision : 1.0  initial release
// ============================================================================
module fixed_prio_enc #(
    parameter int NUM_REQ = 5
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] onehot
);
    logic [NUM_REQ-1:0] w_neg;

    // Two's complement trick: req & -req keeps only the lowest set bit.
    assign w_neg  = ~req + NUM_REQ'(1);
    assign onehot = req & w_neg;
endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Brief    : Burst-locked fixed-priority arbiter for the VGA pixel-write port.
// Revision : 1.0  initial release
// ============================================================================
module vga_plot_arbiter
    import pt_vga_pkg::*;
#(
    parameter int NUM_REQ   = 5,
    parameter int MAX_BURST = 131072,
    parameter int X_RES     = DEF_X_RES,
    parameter int Y_RES     = DEF_Y_RES
) (
    input  logic              clock,
    input  logic              reset,
    vga_plot_arbiter_if.slave bus
);
    localparam int                  c_cnt_w    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(MAX_BURST - 1);
    localparam logic [X_W-1:0]      c_x_lim    = X_W'(X_RES);
    localparam logic [Y_W-1:0]      c_y_lim    = Y_W'(Y_RES);

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_plot;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [COLOUR_W-1:0]  r_colour;
    logic                 r_busy;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [NUM_REQ-1:0]   w_first;
    logic                 w_sel_req;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [X_W-1:0]       w_sel_x;
    logic [Y_W-1:0]       w_sel_y;
    logic [COLOUR_W-1:0]  w_sel_colour;
    logic                 w_pix;
    logic                 w_last_evt;
    logic                 w_abort;
    logic                 w_tmo;

    fixed_prio_enc #(.NUM_REQ(NUM_REQ)) u_enc (
        .req    (bus.req),
        .onehot (w_first)
    );

    // One-hot grant makes an OR-style mux safe: at most one slice is picked.
    always_comb begin
        w_sel_req    = 1'b0;
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_req    = bus.req[i];
                w_sel_valid  = bus.pix_valid[i];
                w_sel_last   = bus.last[i];
                w_sel_x      = bus.x_in[i*X_W +: X_W];
                w_sel_y      = bus.y_in[i*Y_W +: Y_W];
                w_sel_colour = bus.colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign w_pix      = w_sel_valid && (w_sel_x < c_x_lim) && (w_sel_y < c_y_lim);
    assign w_last_evt = w_sel_valid & w_sel_last;
    assign w_abort    = ~w_sel_req;
    assign w_tmo      = (r_cnt == c_cnt_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_plot <= 1'b0;
                    r_cnt  <= '0;
                    if (|bus.req) begin
                        r_grant <= w_first;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                    if (bus.err_clear) r_err <= 1'b0;
                end
                ST_BUSY: begin
                    r_plot <= w_pix;
                    if (w_pix) begin
                        r_x      <= w_sel_x;
                        r_y      <= w_sel_y;
                        r_colour <= w_sel_colour;
                    end
                    if (!w_tmo) r_cnt <= r_cnt + c_cnt_w'(1);
                    // Priority of release causes: last beats abort beats timeout.
                    if (w_last_evt || w_abort || w_tmo) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                    if (!w_last_evt && !w_abort && w_tmo) r_err <= 1'b1;
                    else if (bus.err_clear)               r_err <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.plot        = r_plot;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.colour      = r_colour;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_arbiter
// Brief    : Directed self-checking bench for vga_plot_arbiter (MAX_BURST=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_plot_arbiter;
    import pt_vga_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    vga_plot_arbiter_if #(.NUM_REQ(5)) bus ();

    vga_plot_arbiter #(
        .NUM_REQ   (5),
        .MAX_BURST (16),
        .X_RES     (320),
        .Y_RES     (240)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req       = '0;
        bus.pix_valid = '0;
        bus.last      = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        bus.err_clear = 1'b0;
    endtask

    task automatic set_pix(input int i, input logic v, input logic l,
                           input int px, input int py, input logic [2:0] c);
        bus.pix_valid[i]       = v;
        bus.last[i]            = l;
        bus.x_in[i*9 +: 9]     = 9'(px);
        bus.y_in[i*8 +: 8]     = 8'(py);
        bus.colour_in[i*3 +: 3] = c;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        total++; if (bus.grant !== 5'b00000) begin bad++; $display("FAIL rst_grant got=%b want=00000", bus.grant); end
        total++; if (bus.plot !== 1'b0) begin bad++; $display("FAIL rst_plot got=%b want=0", bus.plot); end
        total++; if ({bus.x, bus.y, bus.colour} !== 20'h0) begin bad++; $display("FAIL rst_xyc got=%h want=0", {bus.x, bus.y, bus.colour}); end
        total++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", bus.busy, bus.timeout_err); end
        reset = 1'b0;
        step();
        total++; if (bus.grant !== 5'b00000) begin bad++; $display("FAIL rst_idle_grant got=%b want=00000", bus.grant); end
    endtask

    task automatic test_single_burst();
        bus.req = 5'b00010;
        step();
        total++; if (bus.grant !== 5'b00010 || bus.busy !== 1'b1) begin bad++; $display("FAIL sb_grant got=%b busy=%b want=00010 1", bus.grant, bus.busy); end
        total++; if (bus.plot !== 1'b0) begin bad++; $display("FAIL sb_noplot got=%b want=0", bus.plot); end
        for (int k = 0; k < 3; k++) begin
            set_pix(1, 1'b1, (k == 2), 10 + k, 20, RED);
            step();
            total++; if (bus.plot !== 1'b1 || bus.x !== 9'(10 + k) || bus.y !== 8'd20 || bus.colour !== RED) begin
                bad++; $display("FAIL sb_pix%0d got=%b %0d %0d %b want=1 %0d 20 100", k, bus.plot, bus.x, bus.y, bus.colour, 10 + k);
            end
        end
        total++; if (bus.grant !== 5'b00000 || bus.busy !== 1'b0) begin bad++; $display("FAIL sb_release got=%b busy=%b want=00000 0", bus.grant, bus.busy); end
        clear_inputs();
        step();
        total++; if (bus.plot !== 1'b0 || bus.x !== 9'd12) begin bad++; $display("FAIL sb_hold got=%b x=%0d want=0 12", bus.plot, bus.x); end
    endtask

    task automatic test_priority();
        bus.req = 5'b10101;
        step();
        total++; if (bus.grant !== 5'b00001) begin bad++; $display("FAIL pr_first got=%b want=00001", bus.grant); end
        set_pix(0, 1'b1, 1'b1, 0, 0, WHITE);
        step();
        total++; if (bus.grant !== 5'b00000 || bus.plot !== 1'b1) begin bad++; $display("FAIL pr_gap got=%b plot=%b want=00000 1", bus.grant, bus.plot); end
        bus.req[0] = 1'b0; set_pix(0, 1'b0, 1'b0, 0, 0, BLACK);
        step();
        total++; if (bus.grant !== 5'b00100) begin bad++; $display("FAIL pr_second got=%b want=00100", bus.grant); end
        set_pix(2, 1'b1, 1'b1, 1, 1, WHITE);
        step();
        total++; if (bus.grant !== 5'b00000) begin bad++; $display("FAIL pr_gap2 got=%b want=00000", bus.grant); end
        bus.req[2] = 1'b0; set_pix(2, 1'b0, 1'b0, 0, 0, BLACK);
        step();
        total++; if (bus.grant !== 5'b10000) begin bad++; $display("FAIL pr_third got=%b want=10000", bus.grant); end
        bus.req[4] = 1'b0;
        step();
        total++; if (bus.grant !== 5'b00000 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL pr_abort got=%b err=%b want=00000 0", bus.grant, bus.timeout_err); end
        clear_inputs();
        step();
    endtask

    task automatic test_no_preempt();
        bus.req = 5'b01000;
        step();
        total++; if (bus.grant !== 5'b01000) begin bad++; $display("FAIL np_grant got=%b want=01000", bus.grant); end
        set_pix(3, 1'b1, 1'b0, 1, 1, WHITE);
        bus.req[0] = 1'b1;
        set_pix(0, 1'b1, 1'b0, 50, 50, RED);
        step();
        total++; if (bus.grant !== 5'b01000) begin bad++; $display("FAIL np_hold got=%b want=01000", bus.grant); end
        total++; if (bus.plot !== 1'b1 || bus.x !== 9'd1 || bus.colour !== WHITE) begin bad++; $display("FAIL np_pix got=%b x=%0d c=%b want=1 1 111", bus.plot, bus.x, bus.colour); end
        set_pix(3, 1'b1, 1'b1, 2, 2, WHITE);
        step();
        total++; if (bus.grant !== 5'b00000 || bus.x !== 9'd2) begin bad++; $display("FAIL np_rel got=%b x=%0d want=00000 2", bus.grant, bus.x); end
        bus.req[3] = 1'b0; set_pix(3, 1'b0, 1'b0, 0, 0, BLACK);
        set_pix(0, 1'b0, 1'b0, 0, 0, BLACK);
        step();
        total++; if (bus.grant !== 5'b00001) begin bad++; $display("FAIL np_hi got=%b want=00001", bus.grant); end
        clear_inputs();
        step();
        total++; if (bus.grant !== 5'b00000) begin bad++; $display("FAIL np_abort got=%b want=00000", bus.grant); end
        step();
    endtask

    task automatic test_clipping();
        bus.req = 5'b00100;
        step();
        set_pix(2, 1'b1, 1'b0, 320, 5, RED);
        step();
        total++; if (bus.plot !== 1'b0 || bus.x !== 9'd2 || bus.y !== 8'd2) begin bad++; $display("FAIL cl_x got=%b %0d %0d want=0 2 2", bus.plot, bus.x, bus.y); end
        set_pix(2, 1'b1, 1'b0, 5, 240, RED);
        step();
        total++; if (bus.plot !== 1'b0 || bus.x !== 9'd2) begin bad++; $display("FAIL cl_y got=%b x=%0d want=0 2", bus.plot, bus.x); end
        set_pix(2, 1'b1, 1'b1, 319, 239, RED);
        step();
        total++; if (bus.plot !== 1'b1 || bus.x !== 9'd319 || bus.y !== 8'd239 || bus.colour !== RED) begin
            bad++; $display("FAIL cl_edge got=%b %0d %0d %b want=1 319 239 100", bus.plot, bus.x, bus.y, bus.colour);
        end
        total++; if (bus.grant !== 5'b00000) begin bad++; $display("FAIL cl_rel got=%b want=00000", bus.grant); end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        bus.req = 5'b00010;
        bus.err_clear = 1'b1;
        step();
        for (int k = 1; k < 16; k++) begin
            step();
            total++; if (bus.grant !== 5'b00010) begin bad++; $display("FAIL to_hold%0d got=%b want=00010", k, bus.grant); end
        end
        step();
        total++; if (bus.grant !== 5'b00000 || bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_fire got=%b err=%b want=00000 1", bus.grant, bus.timeout_err); end
        bus.req = 5'b00000;
        step();
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", bus.timeout_err); end
        bus.err_clear = 1'b0;
        bus.req = 5'b00010;
        step();
        for (int k = 1; k < 16; k++) step();
        set_pix(1, 1'b1, 1'b1, 7, 7, WHITE);
        step();
        total++; if (bus.grant !== 5'b00000 || bus.timeout_err !== 1'b0 || bus.plot !== 1'b1) begin
            bad++; $display("FAIL to_last got=%b err=%b plot=%b want=00000 0 1", bus.grant, bus.timeout_err, bus.plot);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus.req = 5'b00001;
        step();
        set_pix(0, 1'b1, 1'b0, 30, 30, WHITE);
        step();
        total++; if (bus.plot !== 1'b1 || bus.grant !== 5'b00001) begin bad++; $display("FAIL rm_pre got=%b %b want=1 00001", bus.plot, bus.grant); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.grant !== 5'b00000 || bus.plot !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rm_async got=%b %b %b want=00000 0 0", bus.grant, bus.plot, bus.busy);
        end
        step();
        reset = 1'b0;
        step();
        total++; if (bus.grant !== 5'b00001 || bus.plot !== 1'b0) begin bad++; $display("FAIL rm_regrant got=%b plot=%b want=00001 0", bus.grant, bus.plot); end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_burst();
        test_priority();
        test_no_preempt();
        test_clipping();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
Shares the single pixel-write port of the 320x240 VGA adapter between the drawing engines: reset screen, tile draw, colour line, correct-hit and wrong-key. It replaces the combinational priority mux at the top level. Each engine requests the port and receives a grant locked for one whole burst (a rectangle or screen fill). Winning pixels pass through one register stage to the adapter's colour/x/y/plot inputs.

Parameters:
NUM_REQ, 5, number of requesters; index 0 is highest priority (reset screen), then draw, line, correct, incorrect.
MAX_BURST, 131072, grant-hold cycles before forced release (above 320*240=76800).
X_RES, 320, horizontal resolution; pixels with x >= X_RES are clipped.
Y_RES, 240, vertical resolution; pixels with y >= Y_RES are clipped.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
reset  in  1  asynchronous, active-high reset.
req  in  NUM_REQ  per-requester port request, level.
pix_valid  in  NUM_REQ  requester presents a pixel this cycle.
last  in  NUM_REQ  qualifies pix_valid: this pixel is the final one of the burst.
x_in  in  NUM_REQ*9  packed x coordinates; requester i uses bits [9i+8:9i].
y_in  in  NUM_REQ*8  packed y coordinates.
colour_in  in  NUM_REQ*3  packed 3-bit RGB colours.
err_clear  in  1  clears timeout_err.
grant  out  NUM_REQ  one-hot grant, registered.
plot  out  1  write enable to the VGA adapter.
x  out  9  pixel x.
y  out  8  pixel y.
colour  out  3  pixel colour.
busy  out  1  high while in state BUSY.
timeout_err  out  1  sticky flag: a burst was force-released.

Behaviour:
- Reset, asynchronous: grant=0, plot=0, x=0, y=0, colour=0, busy=0, timeout_err=0, burst counter=0, state=IDLE. Reset mid-burst aborts the burst immediately; no pixel is emitted after it.
- FSM states IDLE and BUSY.
- IDLE, any req high: on the next edge, grant = one-hot of the lowest set index. The burst counter clears, busy=1 and state goes to BUSY. Lower-index requesters never preempt an active burst.
- BUSY, granted index g:
  - Each cycle, the outputs register plot <= pix_valid[g] & in-range, plus x/y/colour of slice g. Latency is 1 cycle from input to adapter.
  - pix_valid from non-granted requesters is ignored; their pixels are lost, so they must wait for grant.
  - When plot is low, x, y and colour hold their previous values.
- In-range means x_in < X_RES and y_in < Y_RES. Out-of-range pixels give plot=0 but still count for last handling.
- Release on whichever of these occurs first:
  - (a) pix_valid[g]&last[g], with the last pixel still plotted;
  - (b) req[g] low, an abort with no error;
  - (c) burst counter reaching MAX_BURST-1, which forces release and sets timeout_err.
- On release, grant=0 and busy=0 on the next edge, and state returns to IDLE. The guaranteed gap is at least one cycle with grant=0 between bursts. Re-arbitration happens in IDLE, so a waiting higher-priority request wins over the releasing requester.
- Simultaneous events:
  - last and timeout on the same cycle: last wins, no error.
  - err_clear and timeout set on the same cycle: set wins.
  - req and last both dropping: treat as a normal (a) release.
- Burst counter width is clog2(MAX_BURST). It saturates in IDLE at 0 and never wraps.
- grant is always one-hot or zero. plot=1 implies grant != 0 on the previous cycle.

Decomposition:
- Shared package pt_vga_pkg:
  - widths X_W=9, Y_W=8, COLOUR_W=3;
  - X_RES/Y_RES defaults;
  - requester index constants REQ_RESET=0, REQ_DRAW=1, REQ_LINE=2, REQ_CORRECT=3, REQ_INCORRECT=4;
  - colour constants WHITE=3'b111, RED=3'b100, BLACK=3'b000.
- One sub-module, fixed_prio_enc: NUM_REQ-wide request vector to one-hot, purely combinational, instantiated once.

Test Plan:
- Reset then req=5'b00010, three pixels (10,20,RED), (11,20,RED), (12,20,RED, last) -> grant=00010 one cycle after req; plot high three consecutive cycles, each one cycle after its input; grant=0 the cycle after the last pixel plots.
- req=5'b10101 in IDLE -> grant=00001. After its last, grant=00000 for one cycle, then 00100. Index 4 is served only after index 2 releases.
- Burst owned by index 3, index 0 raises req mid-burst -> no preemption; index 0 granted exactly two cycles after index 3's last pixel.
- Granted requester sends (320,5) and (5,240) -> plot stays 0 for both; (319,239) gives plot=1 with x=319, y=239.
- MAX_BURST=16, granted requester holds req with no last -> grant drops after 16 cycles and timeout_err=1. err_clear pulse -> timeout_err=0. Last on cycle 16 instead -> no error.
- reset asserted mid-burst -> grant, plot and busy go to 0 without a clock edge. After reset release, a pending req is granted as fresh arbitration.
